// File: rtl/uart_pkg.sv
// Shared UART constants: baud select codes, oversampling
// phases and the clock divisor helper.
package uart_pkg;

    localparam int OVERSAMPLE  = 16;
    localparam int SAMPLE_PH0  = 7;
    localparam int STOP_DECIDE = 153;
    localparam int DIV_W       = 16;

    localparam int BAUD_9600   = 9600;
    localparam int BAUD_19200  = 19200;
    localparam int BAUD_38400  = 38400;
    localparam int BAUD_57600  = 57600;
    localparam int BAUD_115200 = 115200;

    typedef enum logic [2:0] {
        SEL_9600   = 3'd0,
        SEL_19200  = 3'd1,
        SEL_38400  = 3'd2,
        SEL_57600  = 3'd3,
        SEL_115200 = 3'd4
    } baud_sel_e;

    typedef enum logic {
        RX_IDLE,
        RX_RECV
    } rx_state_e;

    // Clocks per oversample tick; unused codes fall back to 9600.
    function automatic logic [DIV_W-1:0] bps_dr(
        input int         clk_freq,
        input logic [2:0] sel
    );
        int baud;
        case (sel)
            SEL_19200:  baud = BAUD_19200;
            SEL_38400:  baud = BAUD_38400;
            SEL_57600:  baud = BAUD_57600;
            SEL_115200: baud = BAUD_115200;
            default:    baud = BAUD_9600;
        endcase
        return DIV_W'(clk_freq / (baud * OVERSAMPLE));
    endfunction

    function automatic logic maj3(
        input logic a,
        input logic b,
        input logic c
    );
        return (a & b) | (a & c) | (b & c);
    endfunction

endpackage

// File: rtl/uart_rx_sync.sv
// Two-flop synchroniser for the RX pin plus a delay flop
// that flags the falling edge marking a start bit.
module uart_rx_sync (
    input  logic clk,
    input  logic n_reset,
    input  logic uart_rx,
    output logic rx_s,
    output logic start_edge
);

    logic s1_q;
    logic s2_q;
    logic dly_q;

    always_ff @(posedge clk) begin
        if (!n_reset) begin
            s1_q  <= 1'b1;
            s2_q  <= 1'b1;
            dly_q <= 1'b1;
        end else begin
            s1_q  <= uart_rx;
            s2_q  <= s1_q;
            dly_q <= s2_q;
        end
    end

    assign rx_s       = s2_q;
    assign start_edge = dly_q & ~s2_q;

endmodule

// File: rtl/uart_byte_rx.sv
// 8N1 UART receiver: 16x oversampling, 3-sample majority
// vote, one-cycle done / framing-error strobes.
module uart_byte_rx
    import uart_pkg::*;
#(
    parameter int CLK_FREQ = 50_000_000
) (
    input  logic       clk,
    input  logic       n_reset,
    input  logic [2:0] Baud_set,
    input  logic       uart_rx,
    output logic [7:0] Data,
    output logic       Rx_done,
    output logic       Frame_err
);

    rx_state_e        state;
    rx_state_e        state_nxt;
    logic             rx_s;
    logic             start_edge;
    logic [DIV_W-1:0] div_cnt;
    logic [DIV_W-1:0] div_top;
    logic [7:0]       tick_cnt;
    logic [7:0]       shift;
    logic [1:0]       samp;
    logic [3:0]       phase;
    logic [3:0]       bit_idx;
    logic             tick;
    logic             decide;
    logic             vote;
    logic             done_nxt;
    logic             ferr_nxt;

    uart_rx_sync u_sync (
        .clk        (clk),
        .n_reset    (n_reset),
        .uart_rx    (uart_rx),
        .rx_s       (rx_s),
        .start_edge (start_edge)
    );

    assign phase   = tick_cnt[3:0];
    assign bit_idx = tick_cnt[7:4];
    assign tick    = (state == RX_RECV) && (div_cnt == div_top);
    assign decide  = tick && (phase == 4'(SAMPLE_PH0 + 2));
    // Third vote is the live sample taken on the deciding tick.
    assign vote    = maj3(samp[1], samp[0], rx_s);

    always_comb begin
        state_nxt = state;
        done_nxt  = 1'b0;
        ferr_nxt  = 1'b0;
        unique case (state)
            RX_IDLE: begin
                if (start_edge)
                    state_nxt = RX_RECV;
            end
            RX_RECV: begin
                if (decide) begin
                    if (bit_idx == 4'd0 && vote) begin
                        state_nxt = RX_IDLE;
                    end else if (tick_cnt == 8'(STOP_DECIDE)) begin
                        state_nxt = RX_IDLE;
                        done_nxt  = vote;
                        ferr_nxt  = ~vote;
                    end
                end
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (!n_reset)
            state <= RX_IDLE;
        else
            state <= state_nxt;
    end

    always_ff @(posedge clk) begin
        if (!n_reset) begin
            div_cnt   <= '0;
            div_top   <= '0;
            tick_cnt  <= '0;
            samp      <= '0;
            shift     <= '0;
            Data      <= '0;
            Rx_done   <= 1'b0;
            Frame_err <= 1'b0;
        end else begin
            Rx_done   <= done_nxt;
            Frame_err <= ferr_nxt;
            if (done_nxt)
                Data <= shift;
            if (state == RX_IDLE) begin
                if (start_edge) begin
                    div_cnt  <= '0;
                    tick_cnt <= '0;
                    div_top  <= bps_dr(CLK_FREQ, Baud_set)
                                - DIV_W'(1);
                end
            end else begin
                if (tick) begin
                    div_cnt  <= '0;
                    tick_cnt <= tick_cnt + 8'd1;
                end else begin
                    div_cnt <= div_cnt + DIV_W'(1);
                end
                if (tick && phase == 4'(SAMPLE_PH0))
                    samp[0] <= rx_s;
                if (tick && phase == 4'(SAMPLE_PH0 + 1))
                    samp[1] <= rx_s;
                if (decide && bit_idx >= 4'd1 && bit_idx <= 4'd8)
                    shift <= {vote, shift[7:1]};
            end
        end
    end

endmodule

// File: tb/tb_uart_byte_rx.sv
// Directed plus random frame bench for uart_byte_rx at
// 50 MHz; expectations come from the 8N1 frame rules.
module tb_uart_byte_rx;

    logic       clk      = 1'b0;
    logic       n_reset  = 1'b0;
    logic [2:0] Baud_set = 3'd4;
    logic       uart_rx  = 1'b1;
    logic [7:0] Data;
    logic       Rx_done;
    logic       Frame_err;

    int checks  = 0;
    int errors  = 0;
    int cyc     = 0;
    int n_done  = 0;
    int n_ferr  = 0;
    int done_at = -1;
    int ferr_at = -1;
    logic [7:0] exp_data = 8'h00;

    uart_byte_rx #(
        .CLK_FREQ (50_000_000)
    ) dut (
        .clk       (clk),
        .n_reset   (n_reset),
        .Baud_set  (Baud_set),
        .uart_rx   (uart_rx),
        .Data      (Data),
        .Rx_done   (Rx_done),
        .Frame_err (Frame_err)
    );

    always #5 clk = ~clk;

    always @(posedge clk) cyc <= cyc + 1;

    always @(negedge clk) begin
        if (Rx_done) begin
            n_done++;
            done_at = cyc;
        end
        if (Frame_err) begin
            n_ferr++;
            ferr_at = cyc;
        end
        if (Rx_done || Frame_err) begin
            checks++;
            assert (!(Rx_done && Frame_err)) else begin
                errors++;
                $error("FAIL excl observed both strobes at %0d", cyc);
            end
        end
    end

    task automatic chk(
        input string       tag,
        input logic [31:0] obs,
        input logic [31:0] exp
    );
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%0h expected=%0h",
                   tag, obs, exp);
        end
    endtask

    // Drive one frame, bit k spanning 16*bd cycles. Optional
    // phase-8 spikes, mid-frame Baud_set change, reset abort.
    task automatic send(
        input  logic [7:0] b,
        input  logic       stp,
        input  int         bd,
        input  bit         spike,
        input  int         abort_at,
        input  logic [2:0] sel_mid,
        output int         fall
    );
        logic [9:0] fr;
        int         k;
        fr   = {stp, b, 1'b0};
        fall = 0;
        for (int i = 0; i < 160 * bd; i++) begin
            @(negedge clk);
            if (i == 0) fall = cyc;
            if (i == abort_at) begin
                n_reset = 1'b0;
                uart_rx = 1'b1;
                return;
            end
            k       = i / (16 * bd);
            uart_rx = fr[k];
            if (spike && k >= 1 && k <= 8 &&
                i == (16 * k + 9) * bd - 1)
                uart_rx = ~fr[k];
            if (i == 80 * bd) Baud_set = sel_mid;
        end
    endtask

    task automatic frame(
        input string      tag,
        input logic [7:0] b,
        input logic       stp,
        input int         bd,
        input bit         spike,
        input logic [2:0] sel_mid
    );
        int d0;
        int f0;
        int fall;
        int when;
        d0 = n_done;
        f0 = n_ferr;
        send(b, stp, bd, spike, -1, sel_mid, fall);
        if (stp) exp_data = b;
        when = stp ? done_at : ferr_at;
        chk({tag, "_ndone"}, 32'(n_done - d0), 32'(stp));
        chk({tag, "_nferr"}, 32'(n_ferr - f0), 32'(!stp));
        chk({tag, "_time"}, 32'(when),
            32'(fall + 3 + 154 * bd));
        chk({tag, "_data"}, 32'(Data), 32'(exp_data));
        if (!stp) begin
            @(negedge clk);
            uart_rx = 1'b1;
            repeat (20) @(negedge clk);
        end
    endtask

    initial begin
        int         d0;
        int         f0;
        int         fall;
        int         first;
        logic [7:0] rb;
        logic       rs;

        repeat (3) @(negedge clk);
        chk("rst_data", 32'(Data), 32'h00);
        chk("rst_done", 32'(Rx_done), 32'h0);
        chk("rst_ferr", 32'(Frame_err), 32'h0);
        n_reset = 1'b1;
        repeat (10) @(negedge clk);

        frame("single", 8'h55, 1'b1, 27, 1'b0, 3'd4);

        d0 = n_done;
        f0 = n_ferr;
        uart_rx = 1'b0;
        repeat (54) @(negedge clk);
        uart_rx = 1'b1;
        repeat (11 * 27 - 54) @(negedge clk);
        chk("glitch_ndone", 32'(n_done - d0), 32'h0);
        chk("glitch_nferr", 32'(n_ferr - f0), 32'h0);
        frame("post_glitch", 8'h5A, 1'b1, 27, 1'b0, 3'd4);

        frame("ferr", 8'hA3, 1'b0, 27, 1'b0, 3'd4);

        repeat (30) @(negedge clk);
        frame("b2b0", 8'h00, 1'b1, 27, 1'b1, 3'd4);
        first = done_at;
        frame("b2b1", 8'hFF, 1'b1, 27, 1'b1, 3'd4);
        chk("b2b_gap", 32'(done_at - first), 32'(160 * 27));

        repeat (30) @(negedge clk);
        Baud_set = 3'd3;
        frame("baud_hold", 8'hC6, 1'b1, 54, 1'b0, 3'd4);

        repeat (30) @(negedge clk);
        d0 = n_done;
        f0 = n_ferr;
        send(8'h3C, 1'b1, 27, 1'b0, 80 * 27 + 3, 3'd4, fall);
        @(negedge clk);
        n_reset  = 1'b1;
        exp_data = 8'h00;
        chk("abort_data", 32'(Data), 32'h00);
        chk("abort_done", 32'(Rx_done), 32'h0);
        chk("abort_ferr", 32'(Frame_err), 32'h0);
        repeat (32 * 27) @(negedge clk);
        chk("abort_ndone", 32'(n_done - d0), 32'h0);
        chk("abort_nferr", 32'(n_ferr - f0), 32'h0);
        frame("after_rst", 8'h3C, 1'b1, 27, 1'b0, 3'd4);

        for (int k = 0; k < 4; k++) begin
            rb = 8'($urandom);
            rs = ($urandom_range(0, 3) != 0);
            repeat ($urandom_range(0, 40)) @(negedge clk);
            frame("rand", rb, rs, 27, 1'b0, 3'd4);
        end

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
